load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 172 +++++++++++++++++
 tb/tb_load_store_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: turns a pipeline load/store into a single-beat memory
// request, aligns and extends load data, and flags misaligned, illegal or timed-out accesses.
module load_store_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        AccessErr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam logic [31:0] LP_LAST = 32'(TIMEOUT - 1);

  state_t      r_state;
  logic [31:0] r_cnt;
  logic [1:0]  r_lane;
  logic [2:0]  r_funct3;

  logic        w_access;
  logic        w_legal;
  logic        w_misalign;
  logic [3:0]  w_wstrb;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;

  assign w_access = MemRead | MemWrite;
  assign Stall    = w_access && (r_state != DONE);

  // Legality and alignment of the incoming request; a store outranks a load.
  always_comb begin
    w_legal = 1'b0;
    if (MemWrite) begin
      case (funct3)
        3'b000, 3'b001, 3'b010: w_legal = 1'b1;
        default:                w_legal = 1'b0;
      endcase
    end else begin
      case (funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_legal = 1'b1;
        default:                                w_legal = 1'b0;
      endcase
    end
    case (funct3[1:0])
      2'b01:   w_misalign = ALUResult[0];
      2'b10:   w_misalign = (ALUResult[1:0] != 2'b00);
      default: w_misalign = 1'b0;
    endcase
  end

  // Store strobes and lane-replicated store data.
  always_comb begin
    case (funct3[1:0])
      2'b00: begin
        w_wstrb = 4'b0001 << ALUResult[1:0];
        w_wdata = {4{WriteData[7:0]}};
      end
      2'b01: begin
        w_wstrb = 4'b0011 << ALUResult[1:0];
        w_wdata = {2{WriteData[15:0]}};
      end
      2'b10: begin
        w_wstrb = 4'b1111;
        w_wdata = WriteData;
      end
      default: begin
        w_wstrb = 4'b0000;
        w_wdata = 32'h0000_0000;
      end
    endcase
  end

  // Lane selection and sign/zero extension of the returned word.
  always_comb begin
    case (r_lane)
      2'b00:   w_byte = mem_rdata[7:0];
      2'b01:   w_byte = mem_rdata[15:8];
      2'b10:   w_byte = mem_rdata[23:16];
      default: w_byte = mem_rdata[31:24];
    endcase
    w_half = r_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (r_funct3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b010:  w_load = mem_rdata;
      3'b100:  w_load = {24'h00_0000, w_byte};
      3'b101:  w_load = {16'h0000, w_half};
      default: w_load = 32'h0000_0000;
    endcase
  end

  // Access sequencer with registered bus and result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= 32'd0;
      r_lane    <= 2'b00;
      r_funct3  <= 3'b000;
      ReadData  <= 32'h0000_0000;
      AccessErr <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0000_0000;
      mem_wdata <= 32'h0000_0000;
      mem_wstrb <= 4'b0000;
    end else begin
      case (r_state)
        IDLE: begin
          AccessErr <= 1'b0;
          if (w_access) begin
            r_lane   <= ALUResult[1:0];
            r_funct3 <= funct3;
            r_cnt    <= 32'd0;
            if (w_legal && !w_misalign) begin
              r_state   <= REQ;
              mem_req   <= 1'b1;
              mem_we    <= MemWrite;
              mem_addr  <= {ALUResult[31:2], 2'b00};
              mem_wdata <= MemWrite ? w_wdata : 32'h0000_0000;
              mem_wstrb <= MemWrite ? w_wstrb : 4'b0000;
            end else begin
              // Errors skip the bus entirely and report straight from DONE.
              r_state   <= DONE;
              AccessErr <= 1'b1;
              ReadData  <= 32'h0000_0000;
            end
          end else begin
            r_state <= IDLE;
          end
        end
        REQ: begin
          if (mem_ready || (r_cnt == LP_LAST)) begin
            r_state   <= DONE;
            AccessErr <= !mem_ready;
            ReadData  <= (mem_ready && !mem_we) ? w_load : 32'h0000_0000;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0000_0000;
            mem_wdata <= 32'h0000_0000;
            mem_wstrb <= 4'b0000;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        DONE: begin
          r_state   <= IDLE;
          AccessErr <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed scoreboard bench for load_store_unit: driver queues expectations,
// a memory model checks the bus side and a monitor checks each DONE result.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite;
  logic [2:0]  funct3;
  logic [31:0] ALUResult, WriteData;
  logic [31:0] ReadData;
  logic        Stall, AccessErr;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] rdata;
    int          delay;
    logic [31:0] exp_rd;
    logic        exp_err;
    logic        exp_we;
    logic [31:0] exp_maddr;
    logic [31:0] exp_mwdata;
    logic [3:0]  exp_wstrb;
    int          exp_reqc;
    int          exp_stall;
  } txn_t;

  txn_t exp_q[$];
  txn_t mem_q[$];

  load_store_unit #(.TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .funct3(funct3), .ALUResult(ALUResult), .WriteData(WriteData),
    .ReadData(ReadData), .Stall(Stall), .AccessErr(AccessErr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory model: checks request fields and their stability, answers after 'delay' cycles.
  initial begin
    txn_t cur;
    bit   in_req = 1'b0;
    int   rc = 0;
    mem_ready = 1'b0;
    mem_rdata = 32'h5A5A_5A5A;
    forever begin
      @(negedge clk);
      if (mem_req === 1'b1) begin
        if (!in_req) begin
          if (mem_q.size() == 0) begin
            chk("unexpected_mem_req", {31'd0, mem_req}, 32'd0);
          end else begin
            cur    = mem_q.pop_front();
            in_req = 1'b1;
            rc     = 0;
          end
        end
        if (in_req) begin
          chk("mem_we",    {31'd0, mem_we},    {31'd0, cur.exp_we});
          chk("mem_addr",  mem_addr,           cur.exp_maddr);
          chk("mem_wdata", mem_wdata,          cur.exp_mwdata);
          chk("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, cur.exp_wstrb});
          mem_ready = (rc == cur.delay);
          mem_rdata = cur.rdata;
          rc++;
        end
      end else begin
        if (in_req) begin
          chk("mem_req_cycles", rc, cur.exp_reqc);
          in_req = 1'b0;
        end
        if (!reset) begin
          chk("bus_idle_zero", {mem_we, mem_wstrb, mem_addr | mem_wdata}, 37'd0);
        end
        mem_ready = 1'b0;
        mem_rdata = 32'h5A5A_5A5A;
      end
    end
  end

  // Monitor: DONE is the only cycle with an access requested and Stall low.
  initial begin
    txn_t e;
    int   stall_cnt = 0;
    bit   done_s;
    forever begin
      @(negedge clk);
      done_s = (MemRead | MemWrite) && !Stall;
      if (reset) begin
        stall_cnt = 0;
      end else begin
        if (Stall) stall_cnt++;
        if (!(MemRead | MemWrite) && Stall) chk("stall_when_idle", {31'd0, Stall}, 32'd0);
        if (AccessErr && !done_s) chk("accesserr_outside_done", {31'd0, AccessErr}, 32'd0);
        if (done_s) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("ReadData",     ReadData,               e.exp_rd);
            chk("AccessErr",    {31'd0, AccessErr},     {31'd0, e.exp_err});
            chk("stall_cycles", stall_cnt,              e.exp_stall);
          end
          stall_cnt = 0;
        end
      end
    end
  end

  task automatic run(input bit rd, input bit wr, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] rdata, input int delay,
                     input logic [31:0] exp_rd, input bit exp_err, input bit exp_we,
                     input logic [31:0] exp_maddr, input logic [31:0] exp_mwdata,
                     input logic [3:0] exp_wstrb, input int exp_reqc, input int exp_stall);
    txn_t t;
    bit   seen = 1'b0;
    int   i = 0;
    t.rdata = rdata; t.delay = delay; t.exp_rd = exp_rd; t.exp_err = exp_err;
    t.exp_we = exp_we; t.exp_maddr = exp_maddr; t.exp_mwdata = exp_mwdata;
    t.exp_wstrb = exp_wstrb; t.exp_reqc = exp_reqc; t.exp_stall = exp_stall;
    exp_q.push_back(t);
    if (exp_reqc > 0) mem_q.push_back(t);
    @(posedge clk); #1;
    MemRead = rd; MemWrite = wr; funct3 = f3; ALUResult = addr; WriteData = wdata;
    while (!seen && i < 100) begin
      @(negedge clk);
      if (!Stall) seen = 1'b1;
      i++;
    end
    if (!seen) begin
      $display("FAIL stall_never_dropped: got Stall=1 for 100 cycles expected DONE");
      $fatal(1, "access hung");
    end
    @(posedge clk); #1;
    MemRead = 1'b0; MemWrite = 1'b0; funct3 = 3'b000; ALUResult = 32'h0; WriteData = 32'h0;
  endtask

  initial begin
    reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; funct3 = 3'b000;
    ALUResult = 32'h0; WriteData = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ReadData",  ReadData, 32'h0);
    chk("rst_AccessErr", {31'd0, AccessErr}, 32'd0);
    chk("rst_bus", {mem_req, mem_we, mem_wstrb, mem_addr | mem_wdata}, 38'd0);
    chk("rst_Stall", {31'd0, Stall}, 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (2) @(posedge clk);

    //   rd wr f3      addr          wdata         rdata         dly  exp_rd        err we maddr         mwdata        strb     reqc stall
    run(1, 0, 3'b000, 32'h0000_0103, 32'h0,        32'h80FF_1234, 0,  32'hFFFF_FF80, 0, 0, 32'h0000_0100, 32'h0,        4'b0000, 1,  2);
    run(0, 1, 3'b001, 32'h0000_0202, 32'h0000_BEEF, 32'h1234_5678, 0, 32'h0,         0, 1, 32'h0000_0200, 32'hBEEF_BEEF, 4'b1100, 1,  2);
    run(1, 0, 3'b010, 32'h0000_0301, 32'h0,        32'h0,        0,  32'h0,         1, 0, 32'h0,         32'h0,        4'b0000, 0,  1);
    run(1, 0, 3'b101, 32'h0000_0402, 32'h0,        32'hABCD_0000, 5,  32'h0000_ABCD, 0, 0, 32'h0000_0400, 32'h0,        4'b0000, 6,  7);
    run(1, 0, 3'b010, 32'h0000_0600, 32'h0,        32'hFFFF_FFFF, -1, 32'h0,         1, 0, 32'h0000_0600, 32'h0,        4'b0000, 16, 17);
    run(1, 0, 3'b010, 32'h0000_0604, 32'h0,        32'h2468_1357, 15, 32'h2468_1357, 0, 0, 32'h0000_0604, 32'h0,        4'b0000, 16, 17);
    run(1, 0, 3'b001, 32'h0000_0206, 32'h0,        32'h8001_7FFF, 0,  32'hFFFF_8001, 0, 0, 32'h0000_0204, 32'h0,        4'b0000, 1,  2);
    run(1, 0, 3'b100, 32'h0000_0101, 32'h0,        32'h0000_F200, 1,  32'h0000_00F2, 0, 0, 32'h0000_0100, 32'h0,        4'b0000, 2,  3);
    run(1, 0, 3'b000, 32'h0000_0102, 32'h0,        32'h0070_0000, 0,  32'h0000_0070, 0, 0, 32'h0000_0100, 32'h0,        4'b0000, 1,  2);
    run(1, 0, 3'b011, 32'h0000_0000, 32'h0,        32'h0,        0,  32'h0,         1, 0, 32'h0,         32'h0,        4'b0000, 0,  1);
    run(0, 1, 3'b100, 32'h0000_0000, 32'h0000_00AA, 32'h0,       0,  32'h0,         1, 0, 32'h0,         32'h0,        4'b0000, 0,  1);
    run(0, 1, 3'b001, 32'h0000_0203, 32'h0000_1111, 32'h0,       0,  32'h0,         1, 0, 32'h0,         32'h0,        4'b0000, 0,  1);
    run(1, 1, 3'b100, 32'h0000_0020, 32'h1122_3344, 32'h0,       0,  32'h0,         1, 0, 32'h0,         32'h0,        4'b0000, 0,  1);
    run(1, 1, 3'b001, 32'h0000_0002, 32'h1122_3344, 32'h0,       0,  32'h0,         0, 1, 32'h0,         32'h3344_3344, 4'b1100, 1,  2);
    run(0, 1, 3'b000, 32'h0000_0001, 32'h1234_56A5, 32'h0,       2,  32'h0,         0, 1, 32'h0,         32'hA5A5_A5A5, 4'b0010, 3,  4);
    run(0, 1, 3'b010, 32'h0000_0010, 32'hCAFE_F00D, 32'h0,       1,  32'h0,         0, 1, 32'h0000_0010, 32'hCAFE_F00D, 4'b1111, 2,  3);
    run(1, 0, 3'b000, 32'h0000_0102, 32'h0,        32'h0070_0000, 0,  32'h0000_0070, 0, 0, 32'h0000_0100, 32'h0,        4'b0000, 1,  2);

    // Reset in the second REQ cycle abandons the access after two request cycles.
    begin
      txn_t a;
      a.rdata = 32'h0; a.delay = -1; a.exp_rd = 32'h0; a.exp_err = 1'b0; a.exp_we = 1'b0;
      a.exp_maddr = 32'h0000_0500; a.exp_mwdata = 32'h0; a.exp_wstrb = 4'b0000;
      a.exp_reqc = 2; a.exp_stall = 0;
      mem_q.push_back(a);
    end
    @(posedge clk); #1;
    MemRead = 1'b1; funct3 = 3'b010; ALUResult = 32'h0000_0500;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_ReadData",  ReadData, 32'h0);
    chk("abort_AccessErr", {31'd0, AccessErr}, 32'd0);
    chk("abort_mem_req",   {31'd0, mem_req}, 32'd0);
    chk("abort_bus", {mem_we, mem_wstrb, mem_addr | mem_wdata}, 37'd0);
    @(posedge clk); #1;
    reset = 1'b0; MemRead = 1'b0; funct3 = 3'b000; ALUResult = 32'h0;
    @(posedge clk);
    run(1, 0, 3'b010, 32'h0000_0500, 32'h0,        32'h1357_9BDF, 0,  32'h1357_9BDF, 0, 0, 32'h0000_0500, 32'h0,        4'b0000, 1,  2);

    repeat (4) @(posedge clk);
    chk("exp_q_drained", exp_q.size(), 32'd0);
    chk("mem_q_drained", mem_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1, "bench timeout");
  end

endmodule
